// File: rtl/gpio_pkg.sv
// Shared register map constants and register decode helper for the gpio_port peripheral.
// The interrupt registers exist only when GPIO_IRQ_EN is defined; the offsets are always reserved.
package gpio_pkg;

    localparam logic [4:0]  GPIO_OUT_OFS       = 5'h00;
    localparam logic [4:0]  GPIO_IN_OFS        = 5'h04;
    localparam logic [4:0]  GPIO_DIR_OFS       = 5'h08;
    localparam logic [4:0]  GPIO_IRQ_EN_OFS    = 5'h0C;
    localparam logic [4:0]  GPIO_IRQ_EDGE_OFS  = 5'h10;
    localparam logic [4:0]  GPIO_IRQ_STAT_OFS  = 5'h14;
    localparam logic [4:0]  GPIO_RSVD_OFS      = 5'h18;
    localparam logic [31:0] GPIO_WINDOW        = 32'h20;

    typedef enum logic [2:0] {
        REG_OUT,
        REG_IN,
        REG_DIR,
        REG_IRQ_EN,
        REG_IRQ_EDGE,
        REG_IRQ_STAT,
        REG_NONE
    } gpioReg_e;

    function automatic gpioReg_e decodeReg(input logic [4:0] ofs);
        case (ofs)
            GPIO_OUT_OFS:      return REG_OUT;
            GPIO_IN_OFS:       return REG_IN;
            GPIO_DIR_OFS:      return REG_DIR;
            GPIO_IRQ_EN_OFS:   return REG_IRQ_EN;
            GPIO_IRQ_EDGE_OFS: return REG_IRQ_EDGE;
            GPIO_IRQ_STAT_OFS: return REG_IRQ_STAT;
            default:           return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_port_if.sv
// 32-bit Wishbone slave bundle for gpio_port; signal names are given from the slave's point of view.
interface gpio_port_if;

    logic        stb_i;
    logic        cyc_i;
    logic [31:0] adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic        we_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    modport master (
        output stb_i, cyc_i, adr_i, sel_i, dat_i, we_i,
        input  dat_o, ack_o, err_o, rty_o
    );

    modport slave (
        input  stb_i, cyc_i, adr_i, sel_i, dat_i, we_i,
        output dat_o, ack_o, err_o, rty_o
    );

endinterface

// File: rtl/gpio_sync.sv
// WIDTH-wide, STAGES-deep flop chain that brings asynchronous pad levels into the clk_i domain.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// Parametrised GPIO port on a 32-bit Wishbone slave with registered terminations.
// Define GPIO_IRQ_EN to build the edge-triggered interrupt registers and irq_o.
module gpio_port
    import gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0,
    parameter int          WIDTH        = 8,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    gpio_port_if.slave       bus,
    input  logic [WIDTH-1:0] pin_input,
    output logic [WIDTH-1:0] pin_output,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq_o
);

    logic [4:0]       ofs;
    gpioReg_e         regSel;
    logic             hit;
    logic             bad;
    logic             term;
    logic             wrEn;
    logic             ack_d, ack_q;
    logic             err_d, err_q;
    logic [31:0]      readData;
    logic [31:0]      dat_d, dat_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] pinIn;
    logic             unusedBits;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pin_input),
        .q_o    (pinIn)
    );

    assign ofs        = bus.adr_i[4:0];
    assign regSel     = decodeReg(ofs);
    assign unusedBits = ^bus.dat_i;

    // A new termination is only issued once the previous one has been seen, so a held strobe is served every other cycle.
    always_comb begin
        hit   = bus.stb_i && bus.cyc_i && ((bus.adr_i - BASE_ADDRESS) < GPIO_WINDOW);
        bad   = (ofs >= GPIO_RSVD_OFS) || (ofs[1:0] != 2'b00) || (bus.sel_i != 4'hF);
        term  = hit && !ack_q && !err_q;
        ack_d = term && !bad;
        err_d = term && bad;
        wrEn  = ack_d && bus.we_i;
        dat_d = ack_d ? readData : '0;
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] irqEn_q;
    logic [WIDTH-1:0] irqEdge_q;
    logic [WIDTH-1:0] irqStat_d, irqStat_q;
    logic [WIDTH-1:0] inPrev_q;
    logic [WIDTH-1:0] edgeSeen;
    logic [WIDTH-1:0] w1cMask;
    logic             irq_d, irq_q;

    // A fresh edge outranks a simultaneous write-1-clear so no event is lost.
    always_comb begin
        edgeSeen  = (pinIn & ~inPrev_q & irqEdge_q) | (~pinIn & inPrev_q & ~irqEdge_q);
        w1cMask   = (wrEn && regSel == REG_IRQ_STAT) ? bus.dat_i[WIDTH-1:0] : '0;
        irqStat_d = (irqStat_q & ~w1cMask) | edgeSeen;
        irq_d     = |(irqStat_q & irqEn_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irqEn_q   <= '0;
            irqEdge_q <= '0;
            irqStat_q <= '0;
            inPrev_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            inPrev_q  <= pinIn;
            irqStat_q <= irqStat_d;
            irq_q     <= irq_d;
            if (wrEn && regSel == REG_IRQ_EN) begin
                irqEn_q <= bus.dat_i[WIDTH-1:0];
            end
            if (wrEn && regSel == REG_IRQ_EDGE) begin
                irqEdge_q <= bus.dat_i[WIDTH-1:0];
            end
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        readData = '0;
        case (regSel)
            REG_OUT:      readData[WIDTH-1:0] = out_q;
            REG_IN:       readData[WIDTH-1:0] = pinIn;
            REG_DIR:      readData[WIDTH-1:0] = dir_q;
`ifdef GPIO_IRQ_EN
            REG_IRQ_EN:   readData[WIDTH-1:0] = irqEn_q;
            REG_IRQ_EDGE: readData[WIDTH-1:0] = irqEdge_q;
            REG_IRQ_STAT: readData[WIDTH-1:0] = irqStat_q;
`endif
            default:      readData = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            out_q <= '0;
            dir_q <= '0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= dat_d;
            if (wrEn && regSel == REG_OUT) begin
                out_q <= bus.dat_i[WIDTH-1:0];
            end
            if (wrEn && regSel == REG_DIR) begin
                dir_q <= bus.dat_i[WIDTH-1:0];
            end
        end
    end

    assign bus.ack_o  = ack_q;
    assign bus.err_o  = err_q;
    assign bus.dat_o  = dat_q;
    assign bus.rty_o  = 1'b0;
    assign pin_output = out_q;
    assign pin_oe     = dir_q;

endmodule

// File: tb/tb_gpio_port.sv
// Randomised scoreboard bench for gpio_port against a cycle-level register-map model.
// Follows GPIO_IRQ_EN the same way the design does.
module tb_gpio_port;

    localparam logic [31:0] BASE  = 32'h0000_0140;
    localparam int          WIDTH = 8;
    localparam int          SYNC  = 2;
    localparam logic [31:0] MASK  = 32'h0000_00FF;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ_IMPL = 1'b1;
`else
    localparam bit IRQ_IMPL = 1'b0;
`endif

    typedef struct {
        bit          ack;
        bit          err;
        logic [31:0] dat;
        int          due;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] pins;
    logic [WIDTH-1:0] pinOut;
    logic [WIDTH-1:0] pinOe;
    logic             irq;

    int   vectors;
    int   miscompares;
    int   cycleCount;
    exp_t expQ[$];

    logic [31:0] mOut, mDir, mEn, mEdge, mStat;
    logic        mIrq;
    bit          mTerm;
    logic [31:0] hist [SYNC+2];

    gpio_port_if bus ();

    gpio_port #(
        .BASE_ADDRESS (BASE),
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .pin_input  (pins),
        .pin_output (pinOut),
        .pin_oe     (pinOe),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Register map as seen by a reader during the current cycle.
    function automatic logic [31:0] modelRead(input logic [31:0] ofs);
        case (ofs)
            32'h00:  return mOut;
            32'h04:  return hist[SYNC];
            32'h08:  return mDir;
            32'h0C:  return IRQ_IMPL ? mEn : 32'h0;
            32'h10:  return IRQ_IMPL ? mEdge : 32'h0;
            32'h14:  return IRQ_IMPL ? mStat : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently driven, then check the pin-side outputs.
    task automatic tick();
        logic [31:0] ofs, inNow, inPrev, edges, w1c;
        bit          hit, term, bad;
        logic        nextIrq;
        exp_t        e;
        ofs    = bus.adr_i - BASE;
        hit    = bus.stb_i && bus.cyc_i && (bus.adr_i >= BASE) && (ofs < 32);
        term   = hit && !mTerm;
        bad    = (ofs >= 24) || (bus.adr_i[1:0] != 2'b00) || (bus.sel_i != 4'hF);
        inNow  = hist[SYNC];
        inPrev = hist[SYNC+1];
        if (term) begin
            e.ack = !bad;
            e.err = bad;
            e.dat = bad ? 32'h0 : modelRead(ofs);
            e.due = cycleCount + 1;
            expQ.push_back(e);
        end
        edges   = IRQ_IMPL ? (((inNow & ~inPrev & mEdge) | (~inNow & inPrev & ~mEdge)) & MASK) : 32'h0;
        nextIrq = IRQ_IMPL && ((mStat & mEn) != 0);
        w1c     = 32'h0;
        if (term && !bad && bus.we_i) begin
            case (ofs)
                32'h00: mOut = bus.dat_i & MASK;
                32'h08: mDir = bus.dat_i & MASK;
                32'h0C: if (IRQ_IMPL) mEn = bus.dat_i & MASK;
                32'h10: if (IRQ_IMPL) mEdge = bus.dat_i & MASK;
                32'h14: if (IRQ_IMPL) w1c = bus.dat_i & MASK;
                default: ;
            endcase
        end
        mStat = (mStat & ~w1c) | edges;
        mIrq  = nextIrq;
        mTerm = term;
        for (int k = SYNC + 1; k > 1; k--) begin
            hist[k] = hist[k-1];
        end
        hist[1] = 32'(pins);
        @(posedge clk);
        cycleCount++;
        #1;
        checkOutput("pin_output", 64'(pinOut), 64'(mOut));
        checkOutput("pin_oe", 64'(pinOe), 64'(mDir));
        checkOutput("irq_o", 64'(irq), 64'(mIrq));
        checkOutput("rty_o", 64'(bus.rty_o), 64'h0);
    endtask

    task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input int hold);
        bus.stb_i = 1'b1;
        bus.cyc_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = adr;
        bus.dat_i = dat;
        bus.sel_i = sel;
        repeat (hold) tick();
        bus.stb_i = 1'b0;
        bus.cyc_i = 1'b0;
        bus.we_i  = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: every termination must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ack_o || bus.err_o) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_term: got ack=%0b err=%0b, expected no termination", bus.ack_o, bus.err_o);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("bus_response", {30'h0, bus.ack_o, bus.err_o, bus.dat_o}, {30'h0, e.ack, e.err, e.dat});
                end
            end else begin
                checkOutput("dat_o_idle", 64'(bus.dat_o), 64'h0);
                if (expQ.size() > 0 && expQ[0].due <= cycleCount) begin
                    exp_t e;
                    e = expQ.pop_front();
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL response_timeout: got no termination in cycle %0d, expected ack=%0b err=%0b", cycleCount, e.ack, e.err);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] adr;
        logic [3:0]  sel;
        vectors     = 0;
        miscompares = 0;
        cycleCount  = 0;
        mOut = 0; mDir = 0; mEn = 0; mEdge = 0; mStat = 0; mIrq = 1'b0; mTerm = 1'b0;
        for (int k = 0; k < SYNC + 2; k++) hist[k] = 32'h0;
        pins      = '0;
        bus.stb_i = 1'b0;
        bus.cyc_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        bus.sel_i = 4'hF;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_pin_oe", 64'(pinOe), 64'h0);
        checkOutput("reset_irq", 64'(irq), 64'h0);
        checkOutput("reset_ack", 64'(bus.ack_o), 64'h0);
        rst_n = 1'b1;

        $display("[TB] reset reads");
        applyStimulus(1'b0, BASE + 32'h00, 32'h0, 4'hF, 1);
        applyStimulus(1'b0, BASE + 32'h08, 32'h0, 4'hF, 1);
        applyStimulus(1'b0, BASE + 32'h14, 32'h0, 4'hF, 1);

        $display("[TB] OUT and DIR writes");
        applyStimulus(1'b1, BASE + 32'h00, 32'hFFFF_FFA5, 4'hF, 1);
        applyStimulus(1'b1, BASE + 32'h08, 32'h0000_000F, 4'hF, 1);
        applyStimulus(1'b0, BASE + 32'h00, 32'h0, 4'hF, 1);
        checkOutput("out_a5", 64'(pinOut), 64'hA5);
        checkOutput("dir_0f", 64'(pinOe), 64'h0F);

        $display("[TB] input synchroniser latency");
        pins = 8'h3C;
        applyStimulus(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1);
        applyStimulus(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1);
        applyStimulus(1'b1, BASE + 32'h04, 32'h55, 4'hF, 1);
        applyStimulus(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1);

        $display("[TB] error terminations and misses");
        applyStimulus(1'b1, BASE + 32'h00, 32'h0000_00FF, 4'h3, 1);
        applyStimulus(1'b1, BASE + 32'h1C, 32'h0000_00FF, 4'hF, 1);
        applyStimulus(1'b1, BASE + 32'h02, 32'h0000_00FF, 4'hF, 1);
        applyStimulus(1'b1, BASE + 32'h20, 32'h0000_00FF, 4'hF, 1);
        applyStimulus(1'b1, BASE - 32'h04, 32'h0000_00FF, 4'hF, 1);
        applyStimulus(1'b0, BASE + 32'h00, 32'h0, 4'hF, 1);
        checkOutput("out_kept", 64'(pinOut), 64'hA5);

        $display("[TB] rising edge interrupt and clear");
        applyStimulus(1'b1, BASE + 32'h0C, 32'h01, 4'hF, 1);
        applyStimulus(1'b1, BASE + 32'h10, 32'h01, 4'hF, 1);
        pins = pins | 8'h01;
        repeat (SYNC + 3) tick();
        applyStimulus(1'b0, BASE + 32'h14, 32'h0, 4'hF, 1);
        applyStimulus(1'b1, BASE + 32'h14, 32'h01, 4'hF, 1);
        repeat (2) tick();

        $display("[TB] falling edge against write-1-clear");
        pins = pins | 8'h02;
        repeat (SYNC + 2) tick();
        pins = pins & ~8'h02;
        repeat (SYNC) tick();
        applyStimulus(1'b1, BASE + 32'h14, 32'h02, 4'hF, 1);
        applyStimulus(1'b0, BASE + 32'h14, 32'h0, 4'hF, 1);

        $display("[TB] held strobe");
        applyStimulus(1'b0, BASE + 32'h08, 32'h0, 4'hF, 4);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) pins = WIDTH'($urandom);
            adr = BASE + 32'($urandom_range(0, 8) * 4);
            if ($urandom_range(0, 9) == 0) adr = adr + 32'($urandom_range(1, 3));
            sel = ($urandom_range(0, 9) == 0) ? 4'(($urandom_range(0, 14))) : 4'hF;
            applyStimulus(1'($urandom_range(0, 1)), adr, $urandom, sel, int'($urandom_range(1, 3)));
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (SYNC + 4) tick();
        checkOutput("queue_drained", 64'(expQ.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised general-purpose I/O port on the SoC Wishbone bus, and the successor to the fixed 8-bit GPIO.
- Generalises pin count and adds per-pin direction control, metastability-safe input synchronisation and optional edge-triggered interrupts.
- Bus response is registered.
- Sits beside the other SoC peripherals as a 32-bit Wishbone slave; pins go to top-level pads.

## Interface
- BASE_ADDRESS, 0, byte address of register 0; must be 32-byte aligned
- WIDTH, 8, number of pins, 1..32
- SYNC_STAGES, 2, input synchroniser depth, ≥2
- clk_i  in  1  system clock, all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- stb_i, cyc_i  in  1  Wishbone strobe / cycle
- adr_i  in  32  byte address
- sel_i  in  4  byte selects; only 4'hF is legal
- dat_i  in  32  write data
- dat_o  out  32  read data; 0 when ack_o is low
- we_i  in  1  write enable
- ack_o, err_o  out  1  registered terminations
- rty_o  out  1  tied 0
- pin_input  in  WIDTH  asynchronous pad inputs
- pin_output  out  WIDTH  output data
- pin_oe  out  WIDTH  output enable, 1 = drive
- irq_o  out  1  level interrupt, registered

## Operation
- Register map, as byte offsets from BASE_ADDRESS. Bits ≥ WIDTH read 0 and ignore writes.
  - 0x00 OUT: RW, drives pin_output.
  - 0x04 IN: RO, synchronised pin levels; writes ignored with ack.
  - 0x08 DIR: RW, drives pin_oe.
  - 0x0C IRQ_EN: RW.
  - 0x10 IRQ_EDGE: RW, per pin 1 = rising, 0 = falling.
  - 0x14 IRQ_STAT: read status; write 1 to clear.
- Hit: stb_i && cyc_i && adr_i in [BASE_ADDRESS, BASE_ADDRESS+0x1F].
- Error termination (err_o instead of ack_o, no state change) when the hit is:
  - at offset 0x18–0x1F,
  - at an address with adr_i[1:0] != 0, or
  - with sel_i != 4'hF.
- Input path:
  - pin_input passes through SYNC_STAGES flops to form IN.
  - One further flop holds the previous IN for edge detection.
- IRQ_STAT[n] set when pin n's configured edge is seen on IN, regardless of IRQ_EN.
  - Write-1-clear on the same cycle as a new edge: set wins.
- irq_o is the registered OR of (IRQ_STAT & IRQ_EN).

## Timing
- Reset values (asynchronous, all 0): OUT, DIR, IRQ_EN, IRQ_EDGE, IRQ_STAT, synchroniser flops, ack_o, err_o, irq_o. Consequently pin_output = 0 and pin_oe = 0 (all inputs).
- Bus termination:
  - A hit in cycle N gives ack_o or err_o high in cycle N+1 for exactly one cycle.
  - Rule: term <= hit && !ack_o && !err_o.
  - Back-to-back requests with stb held are therefore served every second cycle.
- Write data and dat_o are sampled/presented with the acknowledging edge. Register updates are visible on outputs in cycle N+1.
- Read of IN returns the value as of cycle N.
- Pin-to-IN latency: SYNC_STAGES cycles. Pin-to-IRQ_STAT: SYNC_STAGES+1. Pin-to-irq_o: SYNC_STAGES+2.
- Reset deassertion mid-transaction: the request is dropped; the master must re-issue it.
- Pins whose IRQ_EDGE changes while the pin is stable must not set status.

## Configuration
- GPIO_IRQ_EN defined: IRQ_EN, IRQ_EDGE and IRQ_STAT are implemented; irq_o as above.
- GPIO_IRQ_EN undefined:
  - Those three registers and the edge-detect flop are removed.
  - Offsets 0x0C–0x14 read 0 and ignore writes (still ack).
  - irq_o tied 0.

## Structure
- gpio_pkg holds the register offset constants (GPIO_OUT_OFS … GPIO_IRQ_STAT_OFS) and the window size 0x20.
- One sub-module: gpio_sync, a WIDTH-wide, SYNC_STAGES-deep flop chain with asynchronous active-low reset.

## Test plan
- Reset, then read 0x00, 0x08 and 0x14 → each acks one cycle after the request with 0; pin_oe = 0; irq_o = 0.
- Write OUT = 0xA5, then DIR = 0x0F (WIDTH=8) → pin_output = 0xA5 and pin_oe = 0x0F in each write's ack cycle; read OUT returns 0xA5.
- Drive pin_input = 0x3C → IN reads 0x00 before SYNC_STAGES cycles have elapsed and 0x3C from cycle SYNC_STAGES onward.
- Request with sel_i = 4'h3, request at offset 0x1C, and request at BASE+0x02 → err_o pulses one cycle each, ack_o stays 0, no register changes.
- IRQ_EN = 0x01 and IRQ_EDGE = 0x01, then pin 0 rises → IRQ_STAT = 0x01 and irq_o high SYNC_STAGES+2 cycles after the edge; write 0x01 to 0x14 → irq_o falls one cycle after the ack.
- Falling edge on pin 1 (IRQ_EDGE[1] = 0) coinciding with a W1C of bit 1 → IRQ_STAT[1] remains 1.
